tt_um_serial_sub_8bit: RTL

Bit-serial 8-bit subtractor with borrow: the companion block to our combinational 8-bit carry-lookahead adder tile. It computes A − B − Bin one bit per clock, LSB first. It uses a three-state FSM with a load/start/done handshake over the standard Tiny Tapeout tile pins. Operands are entered as two byte loads on the shared `ui_in` bus. The result is held on `uo_out` until the next operation completes.

---
 rtl/tt_um_serial_sub_8bit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tt_um_serial_sub_8bit.sv
// Bit-serial 8-bit subtractor (A - B - Bin), LSB first, one bit per clock.
// Operands arrive as two byte loads on ui_in; a start strobe launches an
// 8-cycle shift; the difference and flags are held until the next completion.
module tt_um_serial_sub_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // State bit 0 is busy and state bit 1 is done, so both flags come
    // straight out of the state register with no decode logic.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_a_reg;
    logic [7:0]  r_b_reg;
    logic [7:0]  r_a_sh;
    logic [7:0]  r_b_sh;
    logic [7:0]  r_d_sh;
    logic        r_br;
    logic [2:0]  r_cnt;
    logic [7:0]  r_res;
    logic        r_bout;
    logic        r_zero;

    logic        w_load_a;
    logic        w_load_b;
    logic        w_start;
    logic        w_bin;
    logic        w_accept;
    logic        w_go;
    logic        w_shift;
    logic        w_last;
    logic [1:0]  w_bit;
    logic [7:0]  w_d_next;
    logic        w_br_next;
    logic        w_unused_ok;

    // One full-subtractor bit: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(
        input logic a0,
        input logic b0,
        input logic bi
    );
        logic d;
        logic bo;
        d  = a0 ^ b0 ^ bi;
        bo = (~a0 & b0) | (~(a0 ^ b0) & bi);
        return {bo, d};
    endfunction

    assign w_load_a    = uio_in[0];
    assign w_load_b    = uio_in[1];
    assign w_start     = uio_in[2];
    assign w_bin       = uio_in[3];
    assign w_unused_ok = &{1'b0, uio_in[7:4]};

    // Loads and start are honoured only while not shifting.
    assign w_accept  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_go      = w_accept & w_start;
    assign w_shift   = (r_state == S_SHIFT);
    assign w_last    = w_shift && (r_cnt == 3'd7);

    assign w_bit     = sub_bit(r_a_sh[0], r_b_sh[0], r_br);
    assign w_br_next = w_bit[1];
    assign w_d_next  = {w_bit[0], r_d_sh[7:1]};

    // State register; ena low freezes the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start from IDLE/DONE, finish after the eighth bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 3'd7) w_state_next = S_DONE;
            S_DONE:  if (w_start) w_state_next = S_SHIFT;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture; both strobes together load the same byte into both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_reg <= 8'h00;
            r_b_reg <= 8'h00;
        end else if (ena && w_accept) begin
            if (w_load_a) r_a_reg <= ui_in;
            if (w_load_b) r_b_reg <= ui_in;
        end
    end

    // Shift engine: launch copies pre-edge operands, then one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= 8'h00;
            r_b_sh <= 8'h00;
            r_d_sh <= 8'h00;
            r_br   <= 1'b0;
            r_cnt  <= 3'd0;
        end else if (ena) begin
            if (w_go) begin
                r_a_sh <= r_a_reg;
                r_b_sh <= r_b_reg;
                r_br   <= w_bin;
                r_cnt  <= 3'd0;
            end else if (w_shift) begin
                r_a_sh <= {1'b0, r_a_sh[7:1]};
                r_b_sh <= {1'b0, r_b_sh[7:1]};
                r_d_sh <= w_d_next;
                r_br   <= w_br_next;
                r_cnt  <= r_cnt + 3'd1;
            end
        end
    end

    // Result registers update only on the final shift cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res  <= 8'h00;
            r_bout <= 1'b0;
            r_zero <= 1'b0;
        end else if (ena && w_last) begin
            r_res  <= w_d_next;
            r_bout <= w_br_next;
            r_zero <= (w_d_next == 8'h00);
        end
    end

    assign uo_out  = r_res;
    assign uio_out = {r_zero, r_bout, r_state[1], r_state[0], 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule
